// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter: init pass-through, then one-at-a-time refresh/write/read grants (optional SDRAM_ARBIT_RR_EN)
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ar_req,
    input  logic              ar_end,
    input  logic [3:0]        ar_cmd,
    input  logic [BANK_W-1:0] ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              ar_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t      state_q;
    logic        ar_en_q;
    logic        wr_en_q;
    logic        rd_en_q;
    logic        cke_q;
    logic        pick_wr;
    logic        pick_rd;
    logic [3:0]  cmd_mux;

`ifdef SDRAM_ARBIT_RR_EN
    // Set after a write grant, cleared after a read grant; starts at "read"
    // so the first write/read tie goes to the write block.
    logic last_wr_q;

    // Write/read tie goes to whichever block was not served last.
    always_comb begin
        pick_wr = wr_req && (!rd_req || !last_wr_q);
        pick_rd = rd_req && !pick_wr;
    end
`else
    // Fixed priority: write always beats read on a tie.
    always_comb begin
        pick_wr = wr_req;
        pick_rd = rd_req && !wr_req;
    end
`endif

    // Main FSM: grants are set on the same edge the state enters the served
    // state and cleared on the edge that returns to ARBIT, so every grant is
    // separated by at least one NOP cycle.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q   <= S_INIT;
            ar_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            cke_q     <= 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
            last_wr_q <= 1'b0;
`endif
        end else begin
            cke_q <= 1'b1;
            case (state_q)
                S_INIT: begin
                    if (init_end) begin
                        state_q <= S_ARBIT;
                    end
                end
                S_ARBIT: begin
                    if (ar_req) begin
                        state_q <= S_AREF;
                        ar_en_q <= 1'b1;
                    end else if (pick_wr) begin
                        state_q <= S_WRITE;
                        wr_en_q <= 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
                        last_wr_q <= 1'b1;
`endif
                    end else if (pick_rd) begin
                        state_q <= S_READ;
                        rd_en_q <= 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
                        last_wr_q <= 1'b0;
`endif
                    end
                end
                S_AREF: begin
                    if (ar_end) begin
                        state_q <= S_ARBIT;
                        ar_en_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (wr_end) begin
                        state_q <= S_ARBIT;
                        wr_en_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (rd_end) begin
                        state_q <= S_ARBIT;
                        rd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_ARBIT;
                    ar_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux follows the registered state so the granted block owns the bus
    // from the very cycle its grant is visible.
    always_comb begin
        cmd_mux    = CMD_NOP;
        sdram_bank = '1;
        sdram_addr = '1;
        case (state_q)
            S_INIT: begin
                cmd_mux    = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                cmd_mux    = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            S_WRITE: begin
                cmd_mux    = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            S_READ: begin
                cmd_mux    = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_mux    = CMD_NOP;
                sdram_bank = '1;
                sdram_addr = '1;
            end
        endcase
    end

    assign sdram_cs_n  = cmd_mux[3];
    assign sdram_ras_n = cmd_mux[2];
    assign sdram_cas_n = cmd_mux[1];
    assign sdram_we_n  = cmd_mux[0];
    assign sdram_cke   = cke_q;
    assign ar_en       = ar_en_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;

    // Only the write block may drive dq, and only while it holds the grant.
    assign sdram_dq = (wr_sdram_en && (state_q == S_WRITE)) ? wr_data : {DATA_W{1'bz}};

endmodule
